palette_stream: RTL and testbench



---
 rtl/palette_stream.sv | 186 ++++++++++++++++++
 tb/tb_palette_stream.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/palette_stream.sv
// palette_stream: multi-lane indexed-colour to RGB streamer.
// Walks a frame of palette indices in an external synchronous memory, expands
// each lane through the palette and emits one LANES*24-bit beat per step on a
// valid/ready stream through a 4-entry output FIFO.
// Optional macro PALETTE_STREAM_PAL_WRITE_EN: palette becomes a writable
// register file (reset to the default table); otherwise it is a constant table.
module palette_stream #(
    parameter int LANES       = 2,
    parameter int ADDR_W      = 15,
    parameter int IDX_W       = 4,
    parameter int LANE_STRIDE = 1024,
    parameter int FRAME_LEN   = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_rd,
    output logic [LANES*ADDR_W-1:0]   mem_addr,
    input  logic [LANES*IDX_W-1:0]    mem_q,
    input  logic                      pal_we,
    input  logic [IDX_W-1:0]          pal_idx,
    input  logic [23:0]               pal_rgb,
    output logic [LANES*24-1:0]       out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
);
    localparam int STEP_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int BEAT_W = LANES * 24;
    localparam int PAL_N  = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_r;
    logic [STEP_W-1:0]   step;       // next step to issue
    logic                rd_last;    // read on mem_rd this cycle is the final step
    logic                q_vld;      // mem_q carries data this cycle
    logic                q_last;

    logic [BEAT_W-1:0]   fifo_data [4];
    logic [3:0]          fifo_last;
    logic [1:0]          wr_ptr, rd_ptr;
    logic [2:0]          count;
    logic                push, pop;
    logic [3:0]          committed;
    logic [BEAT_W-1:0]   beat;

    function automatic logic [23:0] default_rgb(input logic [IDX_W-1:0] idx);
        case (32'(idx))
            1:       return 24'h000066;
            2:       return 24'hFF0000;
            3:       return 24'hFF3200;
            4:       return 24'hFFFF00;
            5:       return 24'h33FF00;
            6:       return 24'h009BFF;
            7:       return 24'h6D33FF;
            8:       return 24'hFFD393;
            9:       return 24'hFF99FF;
            10:      return 24'hFF329F;
            11:      return 24'h999999;
            12:      return 24'hFF9999;
            13:      return 24'hFFFFFF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [LANES*ADDR_W-1:0] lane_addrs(input logic [ADDR_W-1:0] b,
                                                           input logic [STEP_W-1:0] s);
        logic [LANES*ADDR_W-1:0] a;
        a = '0;
        for (int k = 0; k < LANES; k++)
            a[k*ADDR_W +: ADDR_W] = b + ADDR_W'(s) + ADDR_W'(k * LANE_STRIDE);
        return a;
    endfunction

`ifdef PALETTE_STREAM_PAL_WRITE_EN
    logic [23:0] pal [PAL_N];

    // Palette register file: defaults on reset, writable in any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAL_N; i++) pal[i] <= default_rgb(IDX_W'(i));
        end else if (pal_we) begin
            pal[pal_idx] <= pal_rgb;
        end
    end
`else
    logic unused_pal;
    assign unused_pal = ^{pal_we, pal_idx, pal_rgb, PAL_N[0]};
`endif

    // Expand each lane's index into its RGB slot, lane 0 in the MSBs
    always_comb begin
        beat = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef PALETTE_STREAM_PAL_WRITE_EN
            beat[(LANES-1-k)*24 +: 24] = pal[mem_q[k*IDX_W +: IDX_W]];
`else
            beat[(LANES-1-k)*24 +: 24] = default_rgb(mem_q[k*IDX_W +: IDX_W]);
`endif
        end
    end

    // Slots already spoken for: buffered beats, data returning now, read in flight
    assign committed = 4'(count) + 4'(q_vld) + 4'(mem_rd);
    assign push      = q_vld;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 3'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];

    // Frame sequencer: issues reads under FIFO credit and tracks frame completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_r   <= '0;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_last  <= 1'b0;
        end else begin
            done    <= 1'b0;
            mem_rd  <= 1'b0;
            rd_last <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    base_r   <= base_addr;
                    busy     <= 1'b1;
                    mem_rd   <= 1'b1;
                    mem_addr <= lane_addrs(base_addr, '0);
                    rd_last  <= (FRAME_LEN == 1);
                    step     <= STEP_W'(1);
                    state    <= (FRAME_LEN == 1) ? DRAIN : RUN;
                end
                RUN: if (committed < 4'd4) begin
                    mem_rd   <= 1'b1;
                    mem_addr <= lane_addrs(base_r, step);
                    step     <= step + STEP_W'(1);
                    if (step == STEP_W'(FRAME_LEN - 1)) begin
                        rd_last <= 1'b1;
                        state   <= DRAIN;
                    end
                end
                DRAIN: if (pop && out_last) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return pipeline and 4-entry output FIFO; reset drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld     <= 1'b0;
            q_last    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_last <= '0;
            for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
        end else begin
            q_vld  <= mem_rd;
            q_last <= rd_last;
            if (push) begin
                fifo_data[wr_ptr] <= beat;
                fifo_last[wr_ptr] <= q_last;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_palette_stream.sv
// Bench for palette_stream: random frame memory, reference model computes each
// beat from address arithmetic and a palette table; random/stalled sink.
module tb_palette_stream;
    localparam int FL = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, start1, out_ready, out_ready1, pal_we;
    logic [3:0]  pal_idx;
    logic [23:0] pal_rgb;
    logic [14:0] base_addr;

    logic        busy, done, mem_rd, out_valid, out_last;
    logic [29:0] mem_addr;
    logic [7:0]  mem_q;
    logic [47:0] out_data;

    logic        busy1, done1, mem_rd1, out_valid1, out_last1;
    logic [29:0] mem_addr1;
    logic [7:0]  mem_q1;
    logic [47:0] out_data1;

    palette_stream #(.LANES(2), .ADDR_W(15), .IDX_W(4), .LANE_STRIDE(1024), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last));

    palette_stream #(.LANES(2), .ADDR_W(15), .IDX_W(4), .LANE_STRIDE(1024), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base_addr),
        .busy(busy1), .done(done1), .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_q(mem_q1),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1));

    logic [3:0]  mem [32768];
    logic [23:0] pal_def [16];
    logic [23:0] pal_m [16];

    // Synchronous frame memory: data the cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd)  mem_q  <= {mem[mem_addr[29:15]],  mem[mem_addr[14:0]]};
        if (mem_rd1) mem_q1 <= {mem[mem_addr1[29:15]], mem[mem_addr1[14:0]]};
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] exp_beat(input int base, input int s);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < 2; k++)
            r[(1-k)*24 +: 24] = pal_m[mem[(base + s + k*1024) % 32768]];
        return r;
    endfunction

    task automatic run_frame(input int base, input bit rnd, input int stall_at,
                             input bit pw, input bit strict);
        logic [47:0] expd [FL];
        int got, issued, cyc, done_cyc;
        got = 0; issued = 0; done_cyc = -1;
        for (int s = 0; s < FL; s++) expd[s] = exp_beat(base, s);
        base_addr = 15'(base);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk("busy_c1", 64'(busy), 64'd1);
        chk("rd_c1", 64'(mem_rd), 64'd1);
        while (done_cyc < 0 && cyc < 300) begin
            if (mem_rd) begin
                chk("addr_l0", 64'(mem_addr[14:0]),  64'((base + issued) % 32768));
                chk("addr_l1", 64'(mem_addr[29:15]), 64'((base + issued + 1024) % 32768));
                issued++;
            end
            start = (cyc == 5);
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10) out_ready = 1'b0;
            else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_at >= 0 && cyc == stall_at + 9) begin
                chk("stall_no_rd", 64'(mem_rd), 64'd0);
                chk("stall_fill", 64'(issued), 64'(got + 4));
                if (pw) begin
                    pal_we = 1'b1; pal_idx = 4'd2; pal_rgb = 24'h123456;
                    pal_m[2] = 24'h123456;
                    for (int s = got + 4; s < FL; s++) expd[s] = exp_beat(base, s);
                end
            end
            if (out_valid && out_ready) begin
                chk("beat_data", 64'(out_data), (got < FL) ? 64'(expd[got]) : 64'hDEAD);
                chk("beat_last", 64'(out_last), 64'(got == FL - 1));
                if (strict) chk("beat_cycle", 64'(cyc), 64'(got + 3));
                got++;
            end
            if (done) begin
                done_cyc = cyc;
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_count", 64'(got), 64'(FL));
                if (strict) chk("done_cycle", 64'(cyc), 64'(FL + 3));
            end
            @(posedge clk); #1;
            cyc++;
            pal_we = 1'b0;
        end
        chk("frame_timeout", 64'(done_cyc >= 0), 64'd1);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            chk("done_once", 64'(done), 64'd0);
            chk("idle_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; out_ready = 1'b1; out_ready1 = 1'b1;
        pal_we = 1'b0; pal_idx = '0; pal_rgb = '0; base_addr = '0;
        pal_def = '{24'h000000, 24'h000066, 24'hFF0000, 24'hFF3200, 24'hFFFF00, 24'h33FF00,
                    24'h009BFF, 24'h6D33FF, 24'hFFD393, 24'hFF99FF, 24'hFF329F, 24'h999999,
                    24'hFF9999, 24'hFFFFFF, 24'h000000, 24'h000000};
        pal_m = pal_def;
        for (int i = 0; i < 32768; i++) mem[i] = 4'($urandom_range(0, 15));

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd", 64'(mem_rd), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-step frame: exact beat and done timing
        mem[0] = 4'h1; mem[1024] = 4'hD;
        base_addr = '0; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        chk("f1_rd_c1", 64'(mem_rd1), 64'd1);
        chk("f1_busy_c1", 64'(busy1), 64'd1);
        @(posedge clk); #1;
        chk("f1_novalid_c2", 64'(out_valid1), 64'd0);
        @(posedge clk); #1;
        chk("f1_valid_c3", 64'(out_valid1), 64'd1);
        chk("f1_data_c3", 64'(out_data1), 64'h000066FFFFFF);
        chk("f1_last_c3", 64'(out_last1), 64'd1);
        @(posedge clk); #1;
        chk("f1_done_c4", 64'(done1), 64'd1);
        chk("f1_busy_c4", 64'(busy1), 64'd0);
        @(posedge clk); #1;
        chk("f1_done_c5", 64'(done1), 64'd0);

        // Full-rate frame with a stray start mid-run
        run_frame(0, 1'b0, -1, 1'b0, 1'b1);

        // Wrapping addresses, random sink, 10-cycle stall (palette write if enabled)
        mem[15'h7F00] = 4'hE; mem[15'h0300] = 4'hF;
`ifdef PALETTE_STREAM_PAL_WRITE_EN
        run_frame(32'h7F00, 1'b1, 6, 1'b1, 1'b0);
`else
        run_frame(32'h7F00, 1'b1, 6, 1'b0, 1'b0);
`endif

        // Reset mid-frame
        base_addr = 15'd100; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rd", 64'(mem_rd), 64'd0);
        chk("mid_rst_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean frame after reset; index 2 must be back to its default
        pal_m = pal_def;
        mem[200] = 4'h2; mem[201] = 4'h2;
        run_frame(200, 1'b1, -1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
